// File: rtl/ahb_byte_sequencer_pkg.sv
// Shared types and decode helpers for the AHB-to-8-bit byte sequencer.
package ahb_byte_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BEAT = 2'b01,
        RESP = 2'b10
    } state_e;

    // HSIZE 11 is deliberately folded onto a single byte
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SIZE_BYTE: len = 3'd1;
            SIZE_HALF: len = 3'd2;
            SIZE_WORD: len = 3'd4;
            default:   len = 3'd1;
        endcase
        return len;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size_to_len(size))
            3'd2:    mis = addr_lo[0];
            3'd4:    mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_byte_sequencer_if.sv
// Request/response channel from the AHB front-end and the 8-bit peripheral beat bus.
interface ahb_byte_req_if #(parameter int ADDR_W = 32) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ahb_byte_bus_if #(parameter int ADDR_W = 32) ();
    logic              byte_valid;
    logic              byte_ready;
    logic              byte_write;
    logic [ADDR_W-1:0] byte_addr;
    logic [7:0]        byte_wdata;
    logic [7:0]        byte_rdata;
    logic              byte_err;

    modport master (
        output byte_valid, byte_write, byte_addr, byte_wdata,
        input  byte_ready, byte_rdata, byte_err
    );

    modport slave (
        input  byte_valid, byte_write, byte_addr, byte_wdata,
        output byte_ready, byte_rdata, byte_err
    );
endinterface

// File: rtl/ahb_byte_sequencer_lane_dp.sv
// Byte-lane datapath: holds the captured write word and assembles read bytes into a word.
module ahb_byte_lane_dp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] wdata_in,
    input  logic [1:0]  wr_lane,
    output logic [7:0]  wr_byte,
    input  logic        rd_we,
    input  logic [1:0]  rd_lane,
    input  logic [7:0]  rd_byte,
    output logic [31:0] rd_word_next
);

    logic [31:0] wdata_r;
    logic [31:0] rdata_r;

    // Write word is loaded once per accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdata_r <= 32'h0000_0000;
        end else if (capture) begin
            wdata_r <= wdata_in;
        end
    end

    // Read buffer starts empty each transfer so unused upper lanes read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (capture || clear) begin
            rdata_r <= 32'h0000_0000;
        end else if (rd_we) begin
            rdata_r <= rd_word_next;
        end
    end

    // Lane select for the next write beat
    always_comb begin
        wr_byte = wdata_r[{wr_lane, 3'b000} +: 8];
    end

    // Merged view includes the byte arriving this cycle, so the last beat can be returned directly
    always_comb begin
        rd_word_next = rdata_r;
        if (rd_we) begin
            rd_word_next[{rd_lane, 3'b000} +: 8] = rd_byte;
        end else begin
            rd_word_next = rdata_r;
        end
    end

endmodule

// File: rtl/ahb_byte_sequencer.sv
// Sequences one AHB transfer as 1/2/4 byte beats on an 8-bit bus and returns a single response.
module ahb_byte_sequencer
    import ahb_byte_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input logic            HCLK,
    input logic            HRESETn,
    ahb_byte_req_if.slave  req,
    ahb_byte_bus_if.master bus
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    state_e            state_r;
    logic [1:0]        cnt_r;
    logic [2:0]        len_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              write_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [31:0]       resp_rdata_r;
    logic              byte_valid_r;
    logic              byte_write_r;
    logic [ADDR_W-1:0] byte_addr_r;
    logic [7:0]        byte_wdata_r;

    logic              accept_s;
    logic              hs_s;
    logic              last_s;
    logic              to_hit_s;
    logic              rd_we_s;
    logic              clear_s;
    logic [1:0]        next_lane_s;
    logic [7:0]        wr_byte_s;
    logic [31:0]       rd_word_s;

    // Handshake qualifiers; byte_ready/byte_err only matter while a beat is offered
    always_comb begin
        accept_s    = (state_r == IDLE) && req.req_valid;
        hs_s        = (state_r == BEAT) && bus.byte_ready;
        last_s      = ({1'b0, cnt_r} == (len_r - 3'd1));
        to_hit_s    = (TIMEOUT != 0) && ((to_cnt_r + TO_W'(1)) == TO_LIM);
        rd_we_s     = hs_s && !write_r;
        clear_s     = (state_r == RESP);
        next_lane_s = cnt_r + 2'd1;
    end

    ahb_byte_lane_dp u_lane_dp (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .capture      (accept_s),
        .clear        (clear_s),
        .wdata_in     (req.req_wdata),
        .wr_lane      (next_lane_s),
        .wr_byte      (wr_byte_s),
        .rd_we        (rd_we_s),
        .rd_lane      (cnt_r),
        .rd_byte      (bus.byte_rdata),
        .rd_word_next (rd_word_s)
    );

    // Transfer FSM with all bus-facing outputs registered
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r      <= IDLE;
            cnt_r        <= 2'd0;
            len_r        <= 3'd0;
            to_cnt_r     <= '0;
            write_r      <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            byte_valid_r <= 1'b0;
            byte_write_r <= 1'b0;
            byte_addr_r  <= '0;
            byte_wdata_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req.req_valid) begin
                        write_r     <= req.req_write;
                        len_r       <= size_to_len(req.req_size);
                        cnt_r       <= 2'd0;
                        to_cnt_r    <= '0;
                        req_ready_r <= 1'b0;
                        if (is_misaligned(req.req_size, req.req_addr[1:0])) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r      <= BEAT;
                            byte_valid_r <= 1'b1;
                            byte_write_r <= req.req_write;
                            byte_addr_r  <= req.req_addr;
                            byte_wdata_r <= req.req_wdata[7:0];
                        end
                    end
                end
                BEAT: begin
                    if (hs_s) begin
                        to_cnt_r <= '0;
                        if (bus.byte_err) begin
                            state_r      <= RESP;
                            byte_valid_r <= 1'b0;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= 32'h0000_0000;
                        end else if (last_s) begin
                            state_r      <= RESP;
                            byte_valid_r <= 1'b0;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_rdata_r <= write_r ? 32'h0000_0000 : rd_word_s;
                        end else begin
                            cnt_r        <= next_lane_s;
                            byte_addr_r  <= byte_addr_r + ADDR_W'(1);
                            byte_wdata_r <= wr_byte_s;
                        end
                    end else if (to_hit_s) begin
                        state_r      <= RESP;
                        byte_valid_r <= 1'b0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= 32'h0000_0000;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 32'h0000_0000;
                    byte_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req.req_ready  = req_ready_r;
    assign req.resp_valid = resp_valid_r;
    assign req.resp_err   = resp_err_r;
    assign req.resp_rdata = resp_rdata_r;
    assign bus.byte_valid = byte_valid_r;
    assign bus.byte_write = byte_write_r;
    assign bus.byte_addr  = byte_addr_r;
    assign bus.byte_wdata = byte_wdata_r;

endmodule

// File: tb/tb_ahb_byte_sequencer.sv
// Randomized scoreboard bench for ahb_byte_sequencer with a plan-driven peripheral model.
module tb_ahb_byte_sequencer;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    always #5 HCLK = ~HCLK;

    ahb_byte_req_if #(.ADDR_W(ADDR_W)) rq ();
    ahb_byte_bus_if #(.ADDR_W(ADDR_W)) bs ();

    ahb_byte_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (rq),
        .bus     (bs)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        write;
        int          stall;
        logic [7:0]  rdata;
        logic        err;
        bit          timeout;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    beat_t beat_q[$];
    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    st[4];
    int    stall_left = 0;
    int    vcnt = 0;
    bit    started = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Expected beats and response are derived from the transfer plan at issue time
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int err_beat, input int to_beat);
        int          len;
        int          total;
        int          g;
        bit          failed;
        logic [31:0] word;
        beat_t       b;
        resp_t       e;
        g = 0;
        while (rq.req_ready !== 1'b1 && g < 300) begin
            @(negedge HCLK);
            g++;
        end
        if (rq.req_ready !== 1'b1) begin
            chk("req_ready_wait", {63'd0, rq.req_ready}, 64'd1);
            return;
        end
        rq.req_valid = 1'b1;
        rq.req_write = w;
        rq.req_size  = sz;
        rq.req_addr  = a;
        rq.req_wdata = wd;
        len    = (sz == 2'b10) ? 4 : ((sz == 2'b01) ? 2 : 1);
        failed = 1'b0;
        word   = 32'd0;
        total  = 0;
        if ((a % len) != 0) begin
            e.rdata = 32'd0;
            e.err   = 1'b1;
            e.cyc   = cyc + 1;
        end else begin
            for (int k = 0; k < len; k++) begin
                b.addr    = a + k;
                b.wdata   = 8'(wd >> (8 * k));
                b.write   = w;
                b.stall   = st[k];
                b.rdata   = 8'(rd >> (8 * k));
                b.err     = (k == err_beat);
                b.timeout = (k == to_beat);
                beat_q.push_back(b);
                word  = word | (32'(b.rdata) << (8 * k));
                total = total + (b.timeout ? TIMEOUT : b.stall + 1);
                if (b.err || b.timeout) begin
                    failed = 1'b1;
                    break;
                end
            end
            e.err   = failed;
            e.rdata = (w || failed) ? 32'd0 : word;
            e.cyc   = cyc + total + 1;
        end
        exp_q.push_back(e);
        @(negedge HCLK);
        rq.req_valid = 1'b0;
        rq.req_write = 1'($urandom);
        rq.req_size  = 2'($urandom);
        rq.req_addr  = $urandom;
        rq.req_wdata = $urandom;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  {63'd0, rq.req_ready},  64'd1);
        chk({tag, "_byte_valid"}, {63'd0, bs.byte_valid}, 64'd0);
        chk({tag, "_resp_valid"}, {63'd0, rq.resp_valid}, 64'd0);
        chk({tag, "_resp_err"},   {63'd0, rq.resp_err},   64'd0);
        chk({tag, "_resp_rdata"}, {32'd0, rq.resp_rdata}, 64'd0);
        chk({tag, "_byte_addr"},  {32'd0, bs.byte_addr},  64'd0);
        chk({tag, "_byte_wdata"}, {56'd0, bs.byte_wdata}, 64'd0);
        chk({tag, "_byte_write"}, {63'd0, bs.byte_write}, 64'd0);
    endtask

    // Peripheral: checks each offered beat against the plan, stalls as planned, then accepts
    initial begin
        beat_t cur;
        bs.byte_ready = 1'b0;
        bs.byte_rdata = 8'h00;
        bs.byte_err   = 1'b0;
        forever begin
            @(negedge HCLK);
            if (bs.byte_valid === 1'b1) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {63'd0, bs.byte_valid}, 64'd0);
                    bs.byte_ready = 1'b1;
                    bs.byte_err   = 1'b0;
                end else begin
                    cur = beat_q[0];
                    chk("beat_fields", {23'd0, bs.byte_write, bs.byte_addr, bs.byte_wdata},
                        {23'd0, cur.write, cur.addr, cur.wdata});
                    started = 1'b1;
                    vcnt++;
                    if (cur.timeout || stall_left < cur.stall) begin
                        stall_left++;
                        bs.byte_ready = 1'b0;
                        bs.byte_err   = 1'($urandom);
                        bs.byte_rdata = 8'($urandom);
                    end else begin
                        bs.byte_ready = 1'b1;
                        bs.byte_rdata = cur.rdata;
                        bs.byte_err   = cur.err;
                        void'(beat_q.pop_front());
                        stall_left = 0;
                        vcnt       = 0;
                        started    = 1'b0;
                    end
                end
            end else begin
                if (started) begin
                    chk("timeout_valid_cycles", vcnt, TIMEOUT);
                    if (beat_q.size() != 0) void'(beat_q.pop_front());
                    stall_left = 0;
                    vcnt       = 0;
                    started    = 1'b0;
                end
                bs.byte_ready = 1'($urandom);
                bs.byte_err   = 1'($urandom);
                bs.byte_rdata = 8'($urandom);
            end
        end
    end

    // Response monitor: every strobe must match the head of the expected queue
    initial begin
        resp_t e;
        forever begin
            @(negedge HCLK);
            if (rq.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {63'd0, rq.resp_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", {32'd0, rq.resp_rdata}, {32'd0, e.rdata});
                    chk("resp_err", {63'd0, rq.resp_err}, {63'd0, e.err});
                    chk("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        int          eb;
        int          tb;
        int          g;
        rq.req_valid = 1'b0;
        rq.req_write = 1'b0;
        rq.req_size  = 2'b00;
        rq.req_addr  = 32'd0;
        rq.req_wdata = 32'd0;
        repeat (2) @(negedge HCLK);
        chk_reset_outputs("reset");
        HRESETn = 1'b1;
        @(negedge HCLK);

        st = '{0, 0, 0, 0};
        issue(1'b1, 2'b10, 32'h0000_0100, 32'hA1B2_C3D4, 32'h0, -1, -1);
        st = '{3, 0, 0, 0};
        issue(1'b0, 2'b01, 32'h0000_0202, 32'h0, 32'h0000_1234, -1, -1);
        st = '{0, 0, 0, 0};
        issue(1'b0, 2'b10, 32'h0000_0101, 32'h0, $urandom, -1, -1);
        issue(1'b0, 2'b10, 32'h0000_0400, 32'h0, $urandom, 1, -1);
        issue(1'b0, 2'b10, 32'h0000_0500, 32'h0, $urandom, -1, 0);
        issue(1'b1, 2'b00, 32'h0000_0007, 32'h0000_005A, $urandom, -1, -1);
        st = '{15, 15, 15, 15};
        issue(1'b0, 2'b01, 32'h0000_0600, 32'h0, $urandom, -1, -1);
        st = '{0, 2, 0, 1};
        issue(1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0, $urandom, -1, -1);
        issue(1'b0, 2'b11, 32'h0000_0703, 32'h0, $urandom, -1, -1);

        // Abandon a word write mid-flight with an asynchronous reset
        st = '{0, 0, 6, 0};
        issue(1'b1, 2'b10, 32'h0000_0800, 32'h1122_3344, 32'h0, -1, -1);
        g = 0;
        while (!(bs.byte_valid === 1'b1 && bs.byte_addr === 32'h0000_0802) && g < 50) begin
            @(negedge HCLK);
            g++;
        end
        chk("rst_reach_beat2", {31'd0, bs.byte_valid, bs.byte_addr}, {31'd0, 1'b1, 32'h0000_0802});
        #2;
        HRESETn = 1'b0;
        beat_q.delete();
        exp_q.delete();
        started    = 1'b0;
        vcnt       = 0;
        stall_left = 0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        st = '{0, 0, 0, 0};
        issue(1'b0, 2'b11, 32'h0000_0903, 32'h0, $urandom, -1, -1);

        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom);
            sz = 2'($urandom);
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) a[31:4] = 28'hFFF_FFFF;
            for (int k = 0; k < 4; k++) begin
                st[k] = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            end
            eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            tb = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
            repeat ($urandom_range(0, 2)) @(negedge HCLK);
            issue(w, sz, a, $urandom, $urandom, eb, tb);
        end

        g = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0) && g < 300) begin
            @(negedge HCLK);
            g++;
        end
        repeat (3) @(negedge HCLK);
        chk("drain_resp", exp_q.size(), 0);
        chk("drain_beats", beat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
